// File: rtl/control_sequencer.sv
// Hard-wired control unit: fetch T0-T2, decode/execute T3-T6.
// Strobes are decoded from the present state and the opcode latched at T2.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t     state, nxt;
    logic [4:0] op;
    logic       first_t1;
    logic       fin;

    logic       two_op, md, un, nop, hlt;
    logic [4:0] alu_sel;
    logic [3:0] alu_code;
    logic       unused_ir;

    assign unused_ir = ^ir[26:0];

    assign two_op = (op >= 5'd3) && (op <= 5'd11);
    assign md     = (op == 5'd15) || (op == 5'd16);
    assign un     = (op == 5'd17) || (op == 5'd18);
    assign nop    = (op == 5'd26);
    assign hlt    = (op == 5'd27);

    // ADD..OR map to 1..9, MUL..NOT map to 10..13
    always_comb begin
        alu_sel = 5'd0;
        if (two_op)
            alu_sel = op - 5'd2;
        else if (md || un)
            alu_sel = op - 5'd5;
    end
    assign alu_code = alu_sel[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op       <= 5'd0;
            first_t1 <= 1'b0;
        end else begin
            state    <= nxt;
            first_t1 <= (state == T0);
            if (state == T2)
                op <= ir[31:27];
        end
    end

    always_comb begin
        nxt      = state;
        fin      = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 4'd0;
        done     = 1'b0;
        unique case (state)
            IDLE: nxt = T0;
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                nxt   = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = first_t1;
                if (mem_ready)
                    nxt = T2;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                nxt    = T3;
            end
            T3: begin
                if (two_op || md) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                    nxt  = T4;
                end else if (un) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = alu_code;
                    nxt    = T4;
                end else if (nop) begin
                    fin = 1'b1;
                end else begin
                    // HALT retires; anything else is illegal
                    done = hlt;
                    nxt  = HALT;
                end
            end
            T4: begin
                if (un) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    fin     = 1'b1;
                end else begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = alu_code;
                    nxt    = T5;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (md) begin
                    LOin = 1'b1;
                    nxt  = T6;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                    fin = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                fin      = 1'b1;
            end
            HALT: nxt = HALT;
            default: nxt = IDLE;
        endcase
        if (fin) begin
            done = 1'b1;
            nxt  = stop ? HALT : T0;
        end
    end

    assign run     = (state != IDLE) && (state != HALT);
    assign illegal = (state == HALT) && !(two_op || md || un || nop || hlt);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-cycle expected strobe vectors are queued
// when an instruction is issued and popped each cycle.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
    logic MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [3:0] alu_op;
    logic run, done, illegal;

    control_sequencer dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .stop(stop), .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
        .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .run(run), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [25:0] PCOUT  = 26'h1 << 25;
    localparam logic [25:0] MARIN  = 26'h1 << 24;
    localparam logic [25:0] INCPC  = 26'h1 << 23;
    localparam logic [25:0] ZIN    = 26'h1 << 22;
    localparam logic [25:0] ZLO    = 26'h1 << 21;
    localparam logic [25:0] ZHI    = 26'h1 << 20;
    localparam logic [25:0] PCIN   = 26'h1 << 19;
    localparam logic [25:0] READ   = 26'h1 << 18;
    localparam logic [25:0] MDRIN  = 26'h1 << 17;
    localparam logic [25:0] MDROUT = 26'h1 << 16;
    localparam logic [25:0] IRIN   = 26'h1 << 15;
    localparam logic [25:0] YIN    = 26'h1 << 14;
    localparam logic [25:0] LOIN   = 26'h1 << 13;
    localparam logic [25:0] HIIN   = 26'h1 << 12;
    localparam logic [25:0] GRA    = 26'h1 << 11;
    localparam logic [25:0] GRB    = 26'h1 << 10;
    localparam logic [25:0] GRC    = 26'h1 << 9;
    localparam logic [25:0] RIN    = 26'h1 << 8;
    localparam logic [25:0] ROUT   = 26'h1 << 7;
    localparam logic [25:0] RUN    = 26'h1 << 2;
    localparam logic [25:0] DONE   = 26'h1 << 1;
    localparam logic [25:0] ILL    = 26'h1;

    logic [25:0] obs;
    assign obs = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
                  Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
                  Gra, Grb, Grc, Rin, Rout, alu_op, run, done, illegal};

    logic [25:0] sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [25:0] got,
                         input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] alu_of(input logic [4:0] o);
        case (o)
            5'd3:  return 4'd1;
            5'd4:  return 4'd2;
            5'd5:  return 4'd3;
            5'd6:  return 4'd4;
            5'd7:  return 4'd5;
            5'd8:  return 4'd6;
            5'd9:  return 4'd7;
            5'd10: return 4'd8;
            5'd11: return 4'd9;
            5'd15: return 4'd10;
            5'd16: return 4'd11;
            5'd17: return 4'd12;
            5'd18: return 4'd13;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] o);
        return {o, 4'd1, 4'd2, 4'd3, 15'd0};
    endfunction

    task automatic push_instr(input logic [4:0] o, input int w);
        logic [25:0] a;
        a = {19'd0, alu_of(o), 3'd0};
        sb.push_back(PCOUT | MARIN | INCPC | ZIN | RUN);
        for (int i = 0; i <= w; i++)
            sb.push_back(ZLO | READ | MDRIN | RUN | ((i == 0) ? PCIN : 26'h0));
        sb.push_back(MDROUT | IRIN | RUN);
        case (o) inside
            [5'd3:5'd11]: begin
                sb.push_back(GRB | ROUT | YIN | RUN);
                sb.push_back(GRC | ROUT | ZIN | a | RUN);
                sb.push_back(ZLO | GRA | RIN | RUN | DONE);
            end
            5'd15, 5'd16: begin
                sb.push_back(GRB | ROUT | YIN | RUN);
                sb.push_back(GRC | ROUT | ZIN | a | RUN);
                sb.push_back(ZLO | LOIN | RUN);
                sb.push_back(ZHI | HIIN | RUN | DONE);
            end
            5'd17, 5'd18: begin
                sb.push_back(GRB | ROUT | ZIN | a | RUN);
                sb.push_back(ZLO | GRA | RIN | RUN | DONE);
            end
            5'd26, 5'd27: sb.push_back(RUN | DONE);
            default:      sb.push_back(RUN);
        endcase
    endtask

    // Pops up to lim entries; a partial run stops without a trailing edge.
    task automatic run_sb(input int lim, input int w, input int stop_from,
                          input string tag);
        int n;
        bit partial;
        n = sb.size();
        partial = (lim < n);
        if (partial) n = lim;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_c%0d", tag, k), obs, sb.pop_front());
            mem_ready = !(k >= 1 && k <= w);
            stop = (k >= stop_from);
            if (k < n - 1 || !partial) begin
                @(posedge clk);
                #1;
            end
        end
        sb.delete();
        stop = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic do_instr(input logic [31:0] iv, input int w,
                            input int stop_from, input string tag);
        ir = iv;
        push_instr(iv[31:27], w);
        run_sb(99, w, stop_from, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ir = 32'h0;
        mem_ready = 1'b1;
        stop = 1'b0;
        #1 check("rst_async", obs, 26'h0);
        repeat (2) @(posedge clk);
        #1 check("rst", obs, 26'h0);
        reset = 1'b1;
        #1 check("idle", obs, 26'h0);
        @(posedge clk);
        #1;

        do_instr(32'h221B8000, 0, 99, "sub");
        do_instr(mk(5'd4), 3, 99, "sub_wait");
        do_instr(32'h7A1B8000, 0, 99, "mul");
        do_instr(mk(5'd16), 1, 99, "div");
        do_instr(mk(5'd17), 0, 99, "neg");
        do_instr(mk(5'd18), 0, 99, "not");
        do_instr(mk(5'd3), 0, 99, "add");
        do_instr(mk(5'd9), 2, 99, "rol");
        do_instr(mk(5'd11), 0, 99, "or");
        do_instr(mk(5'd26), 0, 99, "nop");

        ir = mk(5'd4);
        push_instr(5'd4, 0);
        run_sb(5, 0, 99, "abort");
        reset = 1'b0;
        #1 check("abort_rst", obs, 26'h0);
        @(posedge clk);
        #1 check("abort_hold", obs, 26'h0);
        reset = 1'b1;
        #1 check("abort_idle", obs, 26'h0);
        @(posedge clk);
        #1;

        do_instr(mk(5'd4), 0, 4, "stop");
        check("stop_halt", obs, 26'h0);
        @(posedge clk);
        #1 check("stop_abs", obs, 26'h0);

        reset = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        do_instr(mk(5'd31), 0, 99, "ill");
        check("ill_halt", obs, ILL);
        @(posedge clk);
        #1 check("ill_abs", obs, ILL);
        reset = 1'b0;
        #1 check("ill_rst", obs, 26'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_instr(mk(5'd27), 0, 99, "hlt");
        check("hlt_halt", obs, 26'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
